// File: rtl/bank_isu_pkg.sv
// Shared types and default sizing for the bank instruction scheduling unit.
package bank_isu_pkg;

    localparam int DEF_SETS     = 8;
    localparam int DEF_WAYS     = 8;
    localparam int DEF_CH_W     = 2;
    localparam int DEF_OP_W     = 3;
    localparam int DEF_WBID_W   = 8;
    localparam int DEF_PQ_DEPTH = 4;
    localparam int DEF_SET_W    = $clog2(DEF_SETS);
    localparam int DEF_WAY_W    = $clog2(DEF_WAYS);

    // Request layout at the default sizing; the top builds its own copy from its parameters.
    typedef struct packed {
        logic [DEF_CH_W-1:0]   ch;
        logic [DEF_OP_W-1:0]   op;
        logic [DEF_SET_W-1:0]  set;
        logic [DEF_WAY_W-1:0]  way;
        logic [DEF_WBID_W-1:0] wbid;
    } isu_req_t;

endpackage

// File: rtl/bank_isu_pq.sv
// In-order pending queue of parked requests, with head peek and a per-entry
// set/way match vector used to keep later requests behind parked ones.
module bank_isu_pq
    import bank_isu_pkg::*;
#(
    parameter type req_t    = isu_req_t,
    parameter int  DEPTH    = DEF_PQ_DEPTH,
    parameter int  SET_W    = DEF_SET_W,
    parameter int  WAY_W    = DEF_WAY_W,
    localparam int PTR_W    = $clog2(DEPTH),
    localparam int CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  req_t             push_data,
    input  logic             pop,
    output req_t             head,
    output logic [CNT_W-1:0] cnt,
    input  logic [SET_W-1:0] match_set,
    input  logic [WAY_W-1:0] match_way,
    output logic [DEPTH-1:0] match
);

    req_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

    // An entry is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (({1'b0, PTR_W'(PTR_W'(i) - rd_ptr)} < cnt) &&
                (mem[i].set == match_set) && (mem[i].way == match_way))
                match[i] = 1'b1;
        end
    end

    assert property (@(posedge clk_i) disable iff (rst_i) !(push && !pop && (cnt == CNT_W'(DEPTH))));
    assert property (@(posedge clk_i) disable iff (rst_i) !(pop && (cnt == '0)));

endmodule

// File: rtl/bank_isu_sched.sv
// Bank instruction scheduler: blocks requests to lines with a linefill in flight,
// parks them in order and replays them on completion. Option macro: ISU_PERF_CNT_EN.
module bank_isu_sched
    import bank_isu_pkg::*;
#(
    parameter int  SETS     = DEF_SETS,
    parameter int  WAYS     = DEF_WAYS,
    parameter int  CH_W     = DEF_CH_W,
    parameter int  OP_W     = DEF_OP_W,
    parameter int  WBID_W   = DEF_WBID_W,
    parameter int  PQ_DEPTH = DEF_PQ_DEPTH,
    localparam int SET_W    = $clog2(SETS),
    localparam int WAY_W    = $clog2(WAYS),
    localparam int CNT_W    = $clog2(PQ_DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              htu_valid_i,
    output logic              htu_ready_o,
    input  logic [CH_W-1:0]   htu_ch_i,
    input  logic [OP_W-1:0]   htu_op_i,
    input  logic [SET_W-1:0]  htu_set_i,
    input  logic [WAY_W-1:0]  htu_way_i,
    input  logic [WBID_W-1:0] htu_wbid_i,
    input  logic              lf_start_i,
    input  logic [SET_W-1:0]  lf_set_i,
    input  logic [WAY_W-1:0]  lf_way_i,
    input  logic              lf_done_i,
    input  logic [SET_W-1:0]  lfd_set_i,
    input  logic [WAY_W-1:0]  lfd_way_i,
    output logic              sc_valid_o,
    input  logic              sc_ready_i,
    output logic [CH_W-1:0]   sc_ch_o,
    output logic [OP_W-1:0]   sc_op_o,
    output logic [SET_W-1:0]  sc_set_o,
    output logic [WAY_W-1:0]  sc_way_o,
    output logic [WBID_W-1:0] sc_wbid_o,
    output logic [CNT_W-1:0]  pq_cnt_o,
`ifdef ISU_PERF_CNT_EN
    output logic [31:0]       stall_cnt_o,
`endif
    output logic              err_o
);

    typedef struct packed {
        logic [CH_W-1:0]   ch;
        logic [OP_W-1:0]   op;
        logic [SET_W-1:0]  set;
        logic [WAY_W-1:0]  way;
        logic [WBID_W-1:0] wbid;
    } req_t;

    logic [SETS-1:0][WAYS-1:0] inflight_q;
    logic [SETS-1:0][WAYS-1:0] start_dcd;
    logic [SETS-1:0][WAYS-1:0] done_dcd;
    logic [PQ_DEPTH-1:0]       match;
    req_t                      htu_req;
    req_t                      head_req;
    req_t                      sel_req;
    req_t                      sc_q;
    logic                      sc_valid_q;
    logic                      err_q;
    logic                      head_free;
    logic                      new_free;
    logic                      load;
    logic                      send_head;
    logic                      send_new;
    logic                      accept;
    logic                      push;
    logic                      pop;

    assign htu_req = '{ch: htu_ch_i, op: htu_op_i, set: htu_set_i, way: htu_way_i, wbid: htu_wbid_i};

    always_comb begin
        start_dcd = '0;
        done_dcd  = '0;
        if (lf_start_i) start_dcd[lf_set_i][lf_way_i]   = 1'b1;
        if (lf_done_i)  done_dcd[lfd_set_i][lfd_way_i]  = 1'b1;
    end

    // A start that lands on the same line as a completion wins: the line stays in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            inflight_q <= (inflight_q & ~done_dcd) | start_dcd;
            if ((lf_start_i && inflight_q[lf_set_i][lf_way_i]) ||
                (lf_done_i && !inflight_q[lfd_set_i][lfd_way_i]))
                err_q <= 1'b1;
        end
    end

    bank_isu_pq #(
        .req_t (req_t),
        .DEPTH (PQ_DEPTH),
        .SET_W (SET_W),
        .WAY_W (WAY_W)
    ) u_pq (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push      (push),
        .push_data (htu_req),
        .pop       (pop),
        .head      (head_req),
        .cnt       (pq_cnt_o),
        .match_set (htu_set_i),
        .match_way (htu_way_i),
        .match     (match)
    );

    // The queue head always has priority; a new request may bypass only if nothing
    // for its line is parked, which keeps per-line order intact.
    assign htu_ready_o = (pq_cnt_o != CNT_W'(PQ_DEPTH));
    assign accept      = htu_valid_i && htu_ready_o;
    assign head_free   = (pq_cnt_o != '0) && !inflight_q[head_req.set][head_req.way];
    assign new_free    = accept && !inflight_q[htu_set_i][htu_way_i] && (match == '0);
    assign load        = !sc_valid_q || sc_ready_i;
    assign send_head   = load && head_free;
    assign send_new    = load && !head_free && new_free;
    assign pop         = send_head;
    assign push        = accept && !send_new;
    assign sel_req     = send_head ? head_req : htu_req;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sc_valid_q <= 1'b0;
            sc_q       <= '0;
        end else if (load) begin
            sc_valid_q <= send_head || send_new;
            if (send_head || send_new) sc_q <= sel_req;
        end
    end

    assign sc_valid_o = sc_valid_q;
    assign sc_ch_o    = sc_q.ch;
    assign sc_op_o    = sc_q.op;
    assign sc_set_o   = sc_q.set;
    assign sc_way_o   = sc_q.way;
    assign sc_wbid_o  = sc_q.wbid;
    assign err_o      = err_q;

`ifdef ISU_PERF_CNT_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            stall_cnt_o <= '0;
        else if ((pq_cnt_o != '0) && !head_free && (stall_cnt_o != 32'hFFFF_FFFF))
            stall_cnt_o <= stall_cnt_o + 32'd1;
    end
`endif

endmodule

// File: tb/tb_bank_isu_sched.sv
// Directed self-checking bench for bank_isu_sched at default sizing.
module tb_bank_isu_sched;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       htu_valid_i;
    logic       htu_ready_o;
    logic [1:0] htu_ch_i;
    logic [2:0] htu_op_i;
    logic [2:0] htu_set_i;
    logic [2:0] htu_way_i;
    logic [7:0] htu_wbid_i;
    logic       lf_start_i;
    logic [2:0] lf_set_i;
    logic [2:0] lf_way_i;
    logic       lf_done_i;
    logic [2:0] lfd_set_i;
    logic [2:0] lfd_way_i;
    logic       sc_valid_o;
    logic       sc_ready_i;
    logic [1:0] sc_ch_o;
    logic [2:0] sc_op_o;
    logic [2:0] sc_set_o;
    logic [2:0] sc_way_o;
    logic [7:0] sc_wbid_o;
    logic [2:0] pq_cnt_o;
    logic       err_o;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    bank_isu_sched dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .htu_valid_i (htu_valid_i),
        .htu_ready_o (htu_ready_o),
        .htu_ch_i    (htu_ch_i),
        .htu_op_i    (htu_op_i),
        .htu_set_i   (htu_set_i),
        .htu_way_i   (htu_way_i),
        .htu_wbid_i  (htu_wbid_i),
        .lf_start_i  (lf_start_i),
        .lf_set_i    (lf_set_i),
        .lf_way_i    (lf_way_i),
        .lf_done_i   (lf_done_i),
        .lfd_set_i   (lfd_set_i),
        .lfd_way_i   (lfd_way_i),
        .sc_valid_o  (sc_valid_o),
        .sc_ready_i  (sc_ready_i),
        .sc_ch_o     (sc_ch_o),
        .sc_op_o     (sc_op_o),
        .sc_set_o    (sc_set_o),
        .sc_way_o    (sc_way_o),
        .sc_wbid_o   (sc_wbid_o),
        .pq_cnt_o    (pq_cnt_o),
        .err_o       (err_o)
    );

    task automatic idle_inputs();
        htu_valid_i = 1'b0; htu_ch_i = '0; htu_op_i = '0; htu_set_i = '0; htu_way_i = '0; htu_wbid_i = '0;
        lf_start_i = 1'b0; lf_set_i = '0; lf_way_i = '0;
        lf_done_i = 1'b0; lfd_set_i = '0; lfd_way_i = '0;
        sc_ready_i = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic drive_req(input logic [1:0] ch, input logic [2:0] op, input logic [2:0] set,
                             input logic [2:0] way, input logic [7:0] wbid);
        htu_valid_i = 1'b1; htu_ch_i = ch; htu_op_i = op;
        htu_set_i = set; htu_way_i = way; htu_wbid_i = wbid;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (sc_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL rst_sc_valid got=%0b exp=0", sc_valid_o); end
        total++; if (pq_cnt_o !== 3'd0) begin bad++; $display("[TB] FAIL rst_pq_cnt got=%0d exp=0", pq_cnt_o); end
        total++; if (err_o !== 1'b0) begin bad++; $display("[TB] FAIL rst_err got=%0b exp=0", err_o); end
        total++; if (htu_ready_o !== 1'b1) begin bad++; $display("[TB] FAIL rst_ready got=%0b exp=1", htu_ready_o); end
        total++; if ({sc_ch_o, sc_op_o, sc_set_o, sc_way_o, sc_wbid_o} !== 19'd0) begin
            bad++; $display("[TB] FAIL rst_fields got=%h exp=0", {sc_ch_o, sc_op_o, sc_set_o, sc_way_o, sc_wbid_o}); end
    endtask

    task automatic test_unblocked();
        do_reset();
        drive_req(2'd2, 3'd5, 3'd2, 3'd3, 8'h11);
        @(negedge clk_i);
        htu_valid_i = 1'b0;
        total++; if (sc_valid_o !== 1'b1) begin bad++; $display("[TB] FAIL unblk_valid got=%0b exp=1", sc_valid_o); end
        total++; if ({sc_ch_o, sc_op_o, sc_set_o, sc_way_o} !== {2'd2, 3'd5, 3'd2, 3'd3}) begin
            bad++; $display("[TB] FAIL unblk_fields got=%0d/%0d/%0d/%0d exp=2/5/2/3", sc_ch_o, sc_op_o, sc_set_o, sc_way_o); end
        total++; if (sc_wbid_o !== 8'h11) begin bad++; $display("[TB] FAIL unblk_wbid got=%h exp=11", sc_wbid_o); end
        total++; if (pq_cnt_o !== 3'd0) begin bad++; $display("[TB] FAIL unblk_cnt got=%0d exp=0", pq_cnt_o); end
        @(negedge clk_i);
        total++; if (sc_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL unblk_drop got=%0b exp=0", sc_valid_o); end
    endtask

    task automatic test_block_replay();
        do_reset();
        lf_start_i = 1'b1; lf_set_i = 3'd1; lf_way_i = 3'd5;
        @(negedge clk_i);
        lf_start_i = 1'b0;
        drive_req(2'd1, 3'd1, 3'd1, 3'd5, 8'h22);
        @(negedge clk_i);
        htu_valid_i = 1'b0;
        total++; if (pq_cnt_o !== 3'd1) begin bad++; $display("[TB] FAIL blk_cnt got=%0d exp=1", pq_cnt_o); end
        total++; if (sc_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL blk_valid got=%0b exp=0", sc_valid_o); end
        lf_done_i = 1'b1; lfd_set_i = 3'd1; lfd_way_i = 3'd5;
        @(negedge clk_i);
        lf_done_i = 1'b0;
        total++; if (sc_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL blk_early got=%0b exp=0", sc_valid_o); end
        @(negedge clk_i);
        total++; if (sc_valid_o !== 1'b1 || sc_wbid_o !== 8'h22) begin
            bad++; $display("[TB] FAIL blk_replay got=%0b/%h exp=1/22", sc_valid_o, sc_wbid_o); end
        total++; if (pq_cnt_o !== 3'd0) begin bad++; $display("[TB] FAIL blk_cnt_end got=%0d exp=0", pq_cnt_o); end
    endtask

    task automatic test_bypass_order();
        do_reset();
        lf_start_i = 1'b1; lf_set_i = 3'd1; lf_way_i = 3'd5;
        @(negedge clk_i);
        lf_start_i = 1'b0;
        drive_req(2'd0, 3'd0, 3'd1, 3'd5, 8'h0A);
        @(negedge clk_i);
        drive_req(2'd0, 3'd0, 3'd0, 3'd0, 8'h0B);
        @(negedge clk_i);
        total++; if (sc_valid_o !== 1'b1 || sc_wbid_o !== 8'h0B) begin
            bad++; $display("[TB] FAIL byp_b got=%0b/%h exp=1/0b", sc_valid_o, sc_wbid_o); end
        drive_req(2'd0, 3'd0, 3'd1, 3'd5, 8'h0C);
        @(negedge clk_i);
        htu_valid_i = 1'b0;
        total++; if (pq_cnt_o !== 3'd2 || sc_valid_o !== 1'b0) begin
            bad++; $display("[TB] FAIL byp_park got=%0d/%0b exp=2/0", pq_cnt_o, sc_valid_o); end
        lf_done_i = 1'b1; lfd_set_i = 3'd1; lfd_way_i = 3'd5;
        @(negedge clk_i);
        lf_done_i = 1'b0;
        @(negedge clk_i);
        total++; if (sc_valid_o !== 1'b1 || sc_wbid_o !== 8'h0A) begin
            bad++; $display("[TB] FAIL byp_a got=%0b/%h exp=1/0a", sc_valid_o, sc_wbid_o); end
        @(negedge clk_i);
        total++; if (sc_valid_o !== 1'b1 || sc_wbid_o !== 8'h0C || pq_cnt_o !== 3'd0) begin
            bad++; $display("[TB] FAIL byp_c got=%0b/%h/%0d exp=1/0c/0", sc_valid_o, sc_wbid_o, pq_cnt_o); end
    endtask

    task automatic test_full();
        logic [7:0] exp_wbid [5];
        exp_wbid[0] = 8'h40; exp_wbid[1] = 8'h41; exp_wbid[2] = 8'h42; exp_wbid[3] = 8'h43; exp_wbid[4] = 8'h55;
        do_reset();
        lf_start_i = 1'b1; lf_set_i = 3'd4; lf_way_i = 3'd1;
        @(negedge clk_i);
        lf_start_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_req(2'd0, 3'd0, 3'd4, 3'd1, exp_wbid[i]);
            @(negedge clk_i);
        end
        total++; if (pq_cnt_o !== 3'd4 || htu_ready_o !== 1'b0) begin
            bad++; $display("[TB] FAIL full_cnt got=%0d/%0b exp=4/0", pq_cnt_o, htu_ready_o); end
        drive_req(2'd1, 3'd1, 3'd6, 3'd6, 8'h55);
        lf_done_i = 1'b1; lfd_set_i = 3'd4; lfd_way_i = 3'd1;
        @(negedge clk_i);
        lf_done_i = 1'b0;
        total++; if (htu_ready_o !== 1'b0 || pq_cnt_o !== 3'd4 || sc_valid_o !== 1'b0) begin
            bad++; $display("[TB] FAIL full_hold got=%0b/%0d/%0b exp=0/4/0", htu_ready_o, pq_cnt_o, sc_valid_o); end
        @(negedge clk_i);
        total++; if (htu_ready_o !== 1'b1 || pq_cnt_o !== 3'd3) begin
            bad++; $display("[TB] FAIL full_pop got=%0b/%0d exp=1/3", htu_ready_o, pq_cnt_o); end
        total++; if (sc_valid_o !== 1'b1 || sc_wbid_o !== exp_wbid[0]) begin
            bad++; $display("[TB] FAIL full_out0 got=%0b/%h exp=1/%h", sc_valid_o, sc_wbid_o, exp_wbid[0]); end
        @(negedge clk_i);
        htu_valid_i = 1'b0;
        total++; if (pq_cnt_o !== 3'd3) begin bad++; $display("[TB] FAIL full_pushpop got=%0d exp=3", pq_cnt_o); end
        for (int i = 1; i < 5; i++) begin
            total++; if (sc_valid_o !== 1'b1 || sc_wbid_o !== exp_wbid[i]) begin
                bad++; $display("[TB] FAIL full_out%0d got=%0b/%h exp=1/%h", i, sc_valid_o, sc_wbid_o, exp_wbid[i]); end
            if (i < 4) @(negedge clk_i);
        end
        total++; if (pq_cnt_o !== 3'd0 || sc_set_o !== 3'd6) begin
            bad++; $display("[TB] FAIL full_end got=%0d/%0d exp=0/6", pq_cnt_o, sc_set_o); end
    endtask

    task automatic test_backpressure();
        do_reset();
        sc_ready_i = 1'b0;
        drive_req(2'd1, 3'd2, 3'd3, 3'd2, 8'h21);
        @(negedge clk_i);
        drive_req(2'd0, 3'd0, 3'd5, 3'd5, 8'h22);
        @(negedge clk_i);
        htu_valid_i = 1'b0;
        total++; if (pq_cnt_o !== 3'd1) begin bad++; $display("[TB] FAIL bp_cnt got=%0d exp=1", pq_cnt_o); end
        for (int i = 0; i < 5; i++) begin
            total++; if (sc_valid_o !== 1'b1 || sc_wbid_o !== 8'h21 || sc_set_o !== 3'd3 || sc_way_o !== 3'd2) begin
                bad++; $display("[TB] FAIL bp_hold%0d got=%0b/%h/%0d/%0d exp=1/21/3/2", i, sc_valid_o, sc_wbid_o, sc_set_o, sc_way_o); end
            @(negedge clk_i);
        end
        sc_ready_i = 1'b1;
        @(negedge clk_i);
        total++; if (sc_valid_o !== 1'b1 || sc_wbid_o !== 8'h22 || pq_cnt_o !== 3'd0) begin
            bad++; $display("[TB] FAIL bp_next got=%0b/%h/%0d exp=1/22/0", sc_valid_o, sc_wbid_o, pq_cnt_o); end
    endtask

    task automatic test_error_collision();
        do_reset();
        lf_done_i = 1'b1; lfd_set_i = 3'd3; lfd_way_i = 3'd3;
        @(negedge clk_i);
        lf_done_i = 1'b0;
        total++; if (err_o !== 1'b1) begin bad++; $display("[TB] FAIL err_idle got=%0b exp=1", err_o); end
        lf_start_i = 1'b1; lf_set_i = 3'd2; lf_way_i = 3'd4;
        lf_done_i = 1'b1; lfd_set_i = 3'd2; lfd_way_i = 3'd4;
        @(negedge clk_i);
        lf_start_i = 1'b0; lf_done_i = 1'b0;
        drive_req(2'd0, 3'd0, 3'd2, 3'd4, 8'h31);
        @(negedge clk_i);
        htu_valid_i = 1'b0;
        total++; if (pq_cnt_o !== 3'd1 || sc_valid_o !== 1'b0) begin
            bad++; $display("[TB] FAIL coll_block got=%0d/%0b exp=1/0", pq_cnt_o, sc_valid_o); end
        lf_done_i = 1'b1; lfd_set_i = 3'd2; lfd_way_i = 3'd4;
        @(negedge clk_i);
        lf_done_i = 1'b0;
        @(negedge clk_i);
        total++; if (sc_valid_o !== 1'b1 || sc_wbid_o !== 8'h31) begin
            bad++; $display("[TB] FAIL coll_replay got=%0b/%h exp=1/31", sc_valid_o, sc_wbid_o); end
        total++; if (err_o !== 1'b1) begin bad++; $display("[TB] FAIL err_sticky got=%0b exp=1", err_o); end
    endtask

    task automatic test_reset_mid();
        lf_start_i = 1'b1; lf_set_i = 3'd7; lf_way_i = 3'd7;
        @(negedge clk_i);
        lf_start_i = 1'b0;
        drive_req(2'd0, 3'd0, 3'd7, 3'd7, 8'h77);
        @(negedge clk_i);
        htu_valid_i = 1'b0;
        total++; if (pq_cnt_o !== 3'd1) begin bad++; $display("[TB] FAIL mid_park got=%0d exp=1", pq_cnt_o); end
        #2 rst_i = 1'b1;
        #1;
        total++; if (pq_cnt_o !== 3'd0 || sc_valid_o !== 1'b0 || err_o !== 1'b0) begin
            bad++; $display("[TB] FAIL mid_async got=%0d/%0b/%0b exp=0/0/0", pq_cnt_o, sc_valid_o, err_o); end
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        total++; if (pq_cnt_o !== 3'd0 || sc_valid_o !== 1'b0) begin
            bad++; $display("[TB] FAIL mid_noreplay got=%0d/%0b exp=0/0", pq_cnt_o, sc_valid_o); end
    endtask

    initial begin
        rst_i = 1'b1;
        idle_inputs();
        test_reset();
        test_unblocked();
        test_block_replay();
        test_bypass_order();
        test_full();
        test_backpressure();
        test_error_collision();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
